// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP sequencing controller: FSM states,
// window geometry and the neighbour-to-code-bit map.
package lbp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LAST,
    WRITE,
    DONE
  } state_t;

  localparam int WIN_SIZE = 9;
  localparam int CENTRE   = 4;

  // Code bit b takes its neighbour from window index NBR_IDX[b]; the centre is skipped.
  localparam int NBR_IDX [8] = '{0, 1, 2, 3, 5, 6, 7, 8};

  function automatic logic [1:0] win_dr(input logic [3:0] k);
    case (k)
      4'd0, 4'd1, 4'd2: win_dr = 2'd0;
      4'd3, 4'd4, 4'd5: win_dr = 2'd1;
      default:          win_dr = 2'd2;
    endcase
  endfunction

  function automatic logic [1:0] win_dc(input logic [3:0] k);
    case (k)
      4'd0, 4'd3, 4'd6: win_dc = 2'd0;
      4'd1, 4'd4, 4'd7: win_dc = 2'd1;
      default:          win_dc = 2'd2;
    endcase
  endfunction

endpackage

// File: rtl/step_counter.sv
// Up-counter with enable and synchronous clear to a configurable value;
// reset also loads the clear value.
module step_counter #(
  parameter int           W       = 4,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= CLR_VAL;
    end else if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/lbp_ctrl.sv
// LBP sequencing controller: scans interior pixels, fetches each 3x3 window
// from image memory and writes the 8-bit LBP code to result memory.
module lbp_ctrl
  import lbp_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int AW    = 14,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          gray_ready,
  output logic          gray_req,
  output logic [AW-1:0] gray_addr,
  input  logic [DW-1:0] gray_data,
  output logic          lbp_valid,
  output logic [AW-1:0] lbp_addr,
  output logic [7:0]    lbp_data,
  output logic          finish
);

  localparam int RW = $clog2(IMG_W);

  state_t          state;
  logic [RW-1:0]   row;
  logic [RW-1:0]   col;
  logic [3:0]      k;
  logic [DW-1:0]   g   [WIN_SIZE];
  logic [DW-1:0]   win [WIN_SIZE];
  logic [7:0]      code;

  logic            start;
  logic            k_last;
  logic            last_col;
  logic            last_pix;
  logic [RW-1:0]   nrow;
  logic [RW-1:0]   ncol;

  logic            k_en, k_clr;
  logic            col_en, col_clr;
  logic            row_en, row_clr;

  function automatic logic [AW-1:0] win_addr(input logic [RW-1:0] r,
                                             input logic [RW-1:0] c,
                                             input logic [3:0]    kk);
    logic [RW-1:0] ar;
    logic [RW-1:0] ac;
    ar = r + RW'(win_dr(kk)) - RW'(1);
    ac = c + RW'(win_dc(kk)) - RW'(1);
    return AW'({ar, ac});
  endfunction

  assign start    = (state == IDLE) && gray_ready;
  assign k_last   = (k == 4'(WIN_SIZE - 1));
  assign last_col = (col == RW'(IMG_W - 2));
  assign last_pix = last_col && (row == RW'(IMG_W - 2));
  assign nrow     = last_col ? row + RW'(1) : row;
  assign ncol     = last_col ? RW'(1) : col + RW'(1);

  assign k_en    = (state == READ);
  assign k_clr   = (state != READ) || k_last;
  assign col_en  = (state == WRITE);
  assign col_clr = start || ((state == WRITE) && last_col);
  assign row_en  = (state == WRITE) && last_col;
  assign row_clr = start;

  step_counter #(.W(4), .CLR_VAL(4'd0)) u_step (
    .clk (clk),
    .rst (rst),
    .en  (k_en),
    .clr (k_clr),
    .q   (k)
  );

  step_counter #(.W(RW), .CLR_VAL(RW'(1))) u_col (
    .clk (clk),
    .rst (rst),
    .en  (col_en),
    .clr (col_clr),
    .q   (col)
  );

  step_counter #(.W(RW), .CLR_VAL(RW'(1))) u_row (
    .clk (clk),
    .rst (rst),
    .en  (row_en),
    .clr (row_clr),
    .q   (row)
  );

  // In LAST the final neighbour is still on gray_data, so the code uses it directly.
  always_comb begin
    for (int i = 0; i < WIN_SIZE - 1; i++) begin
      win[i] = g[i];
    end
    win[WIN_SIZE-1] = gray_data;
    code = '0;
    for (int b = 0; b < 8; b++) begin
      code[b] = (win[NBR_IDX[b]] >= win[CENTRE]);
    end
  end

  // Outputs are registered one edge ahead so they line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gray_req  <= 1'b0;
      gray_addr <= '0;
      lbp_valid <= 1'b0;
      lbp_addr  <= '0;
      lbp_data  <= '0;
      finish    <= 1'b0;
      for (int i = 0; i < WIN_SIZE; i++) begin
        g[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (gray_ready) begin
            state     <= READ;
            gray_req  <= 1'b1;
            gray_addr <= '0;
          end
        end
        READ: begin
          if (k != 4'd0) begin
            g[k - 4'd1] <= gray_data;
          end
          if (k_last) begin
            state    <= LAST;
            gray_req <= 1'b0;
          end else begin
            gray_addr <= win_addr(row, col, k + 4'd1);
          end
        end
        LAST: begin
          g[WIN_SIZE-1] <= gray_data;
          state         <= WRITE;
          lbp_valid     <= 1'b1;
          lbp_addr      <= AW'({row, col});
          lbp_data      <= code;
        end
        WRITE: begin
          lbp_valid <= 1'b0;
          if (last_pix) begin
            state  <= DONE;
            finish <= 1'b1;
          end else begin
            state     <= READ;
            gray_req  <= 1'b1;
            gray_addr <= win_addr(nrow, ncol, 4'd0);
          end
        end
        DONE: begin
          finish <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lbp_ctrl.sv
// Scoreboard bench for lbp_ctrl: a 128-wide instance for address sequencing and
// mid-run reset, and an 8-wide instance for complete scans against a reference model.
module tb_lbp_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, rdy_a, req_a, val_a, fin_a;
  logic [13:0] addr_a, laddr_a;
  logic [7:0]  gdata_a = 8'h00;
  logic [7:0]  ldata_a;

  logic        rst_b, rdy_b, req_b, val_b, fin_b;
  logic [5:0]  addr_b, laddr_b;
  logic [7:0]  gdata_b = 8'h00;
  logic [7:0]  ldata_b;

  logic [7:0] img_a [16384];
  logic [7:0] img_b [64];

  lbp_ctrl #(.IMG_W(128), .AW(14), .DW(8)) dut_a (
    .clk        (clk),
    .rst        (rst_a),
    .gray_ready (rdy_a),
    .gray_req   (req_a),
    .gray_addr  (addr_a),
    .gray_data  (gdata_a),
    .lbp_valid  (val_a),
    .lbp_addr   (laddr_a),
    .lbp_data   (ldata_a),
    .finish     (fin_a)
  );

  lbp_ctrl #(.IMG_W(8), .AW(6), .DW(8)) dut_b (
    .clk        (clk),
    .rst        (rst_b),
    .gray_ready (rdy_b),
    .gray_req   (req_b),
    .gray_addr  (addr_b),
    .gray_data  (gdata_b),
    .lbp_valid  (val_b),
    .lbp_addr   (laddr_b),
    .lbp_data   (ldata_b),
    .finish     (fin_b)
  );

  // Host image memories: read data appears the cycle after the request.
  always @(posedge clk) if (req_a) gdata_a <= img_a[addr_a];
  always @(posedge clk) if (req_b) gdata_b <= img_b[addr_b];

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  int checks = 0;
  int failures = 0;
  int pcyc = 0;
  int start_a = 0, start_b = 0;
  int writes_a = 0, writes_b = 0;
  int last_addr_b = 0;
  bit mon_a = 1'b0, mon_b = 1'b0;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int refCode(input int w[9]);
    int code = 0;
    int bitpos = 0;
    for (int n = 0; n < 9; n++) begin
      if (n != 4) begin
        if (w[n] >= w[4]) code += (1 << bitpos);
        bitpos++;
      end
    end
    return code;
  endfunction

  // Expected writes in raster order over interior pixels, one every 11 cycles.
  task automatic pushModel(input bit sel);
    int wd = sel ? 8 : 128;
    int n = 0;
    int w[9];
    exp_t e;
    for (int r = 1; r <= wd - 2; r++) begin
      for (int c = 1; c <= wd - 2; c++) begin
        for (int dr = 0; dr < 3; dr++) begin
          for (int dc = 0; dc < 3; dc++) begin
            int a = (r - 1 + dr) * wd + (c - 1 + dc);
            w[dr*3+dc] = sel ? int'(img_b[a]) : int'(img_a[a]);
          end
        end
        e.addr = r * wd + c;
        e.data = refCode(w);
        e.cyc  = 11 * n + 11;
        if (sel) q_b.push_back(e);
        else     q_a.push_back(e);
        n++;
      end
    end
  endtask

  task automatic applyStimulus(input bit sel);
    @(negedge clk);
    if (sel) begin
      rdy_b = 1'b1;
      start_b = pcyc;
    end else begin
      rdy_a = 1'b1;
      start_a = pcyc;
    end
    @(negedge clk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_a && !rst_a && val_a) begin
      checkOutput("overlap_a", 32'(req_a), 32'd0);
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL extra_write_a: write to %0d with no expected entry", laddr_a);
      end else begin
        ea = q_a.pop_front();
        checkOutput("lbp_addr_a", 32'(laddr_a), ea.addr);
        checkOutput("lbp_data_a", 32'(ldata_a), ea.data);
        checkOutput("lbp_cycle_a", pcyc - start_a, ea.cyc);
        writes_a++;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_b && !rst_b && val_b) begin
      checkOutput("overlap_b", 32'(req_b), 32'd0);
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL extra_write_b: write to %0d with no expected entry", laddr_b);
      end else begin
        eb = q_b.pop_front();
        checkOutput("lbp_addr_b", 32'(laddr_b), eb.addr);
        checkOutput("lbp_data_b", 32'(ldata_b), eb.data);
        checkOutput("lbp_cycle_b", pcyc - start_b, eb.cyc);
        writes_b++;
        last_addr_b = int'(laddr_b);
      end
    end
  end

  // Full 8x8 scan: 36 writes, finish in cycle 397 and held afterwards.
  task automatic runSmall(input string name);
    int fin_cyc = -1;
    q_b.delete();
    pushModel(1'b1);
    writes_b = 0;
    mon_b = 1'b1;
    applyStimulus(1'b1);
    for (int i = 0; i < 500 && fin_cyc < 0; i++) begin
      if (fin_b) fin_cyc = pcyc - start_b;
      else @(negedge clk);
    end
    checkOutput({name, "_finish_cycle"}, fin_cyc, 397);
    repeat (20) @(negedge clk);
    checkOutput({name, "_finish_held"}, 32'(fin_b), 32'd1);
    checkOutput({name, "_writes"}, writes_b, 36);
    checkOutput({name, "_last_addr"}, last_addr_b, 54);
    checkOutput({name, "_queue_left"}, q_b.size(), 0);
    mon_b = 1'b0;
  endtask

  int first_addr [9] = '{0, 1, 2, 128, 129, 130, 256, 257, 258};
  int first_pix  [9] = '{101, 99, 100, 0, 100, 200, 100, 50, 255};

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    for (int i = 0; i < 16384; i++) img_a[i] = 8'($urandom);
    for (int i = 0; i < 9; i++) img_a[first_addr[i]] = 8'(first_pix[i]);
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs_a", {req_a, val_a, fin_a, addr_a, laddr_a, ldata_a}, 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("idle_strobes_a", {29'd0, req_a, val_a, fin_a}, 32'd0);
    end

    pushModel(1'b0);
    writes_a = 0;
    mon_a = 1'b1;
    applyStimulus(1'b0);
    for (int i = 0; i < 9; i++) begin
      checkOutput("first_req", 32'(req_a), 32'd1);
      checkOutput("first_addr", 32'(addr_a), first_addr[i]);
      @(negedge clk);
    end
    checkOutput("last_req_low", 32'(req_a), 32'd0);
    @(negedge clk);
    checkOutput("first_valid", 32'(val_a), 32'd1);
    checkOutput("first_lbp_addr", 32'(laddr_a), 32'd129);
    checkOutput("first_code", 32'(ldata_a), 32'hB5);

    while (pcyc - start_a < 1105) @(negedge clk);
    checkOutput("writes_before_rst", writes_a, 100);
    rst_a = 1'b1;
    #1;
    checkOutput("rst_outputs_a", {req_a, val_a, fin_a, addr_a, laddr_a, ldata_a}, 32'd0);
    mon_a = 1'b0;
    q_a.delete();
    repeat (2) @(negedge clk);
    rst_a = 1'b0;

    pushModel(1'b0);
    writes_a = 0;
    mon_a = 1'b1;
    applyStimulus(1'b0);
    checkOutput("restart_req", 32'(req_a), 32'd1);
    checkOutput("restart_addr", 32'(addr_a), 32'd0);
    while (pcyc - start_a < 45) @(negedge clk);
    checkOutput("restart_writes", writes_a, 4);
    rst_a = 1'b1;
    mon_a = 1'b0;

    for (int i = 0; i < 64; i++) img_b[i] = 8'h55;
    runSmall("uniform");
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0;
    for (int i = 0; i < 64; i++) img_b[i] = 8'($urandom);
    runSmall("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lbp_ctrl.md
# lbp_ctrl

Sequencing controller for the local-binary-pattern (LBP) engine. It walks every interior pixel of a square grayscale image and fetches each pixel's 3×3 window from host image memory. For each pixel it computes the 8-bit LBP code and writes it to host result memory. Row, column and window-step positions are held in counter instances that this FSM enables and clears; the host sees only the memory-request/write interface and a `finish` flag.

## Interface
Parameters:
- `IMG_W`, default 128: image width and height in pixels; must be a power of two and at least 4.
- `AW`, default 14: address width, equal to log2(IMG_W·IMG_W).
- `DW`, default 8: pixel width.

Ports:
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, asynchronous, active-high.
- `gray_ready`, input, 1: host image memory is loaded; sampled only in IDLE.
- `gray_req`, output, 1: read strobe for image memory.
- `gray_addr`, output, AW: read address.
- `gray_data`, input, DW: read data, valid the cycle after `gray_req`.
- `lbp_valid`, output, 1: one-cycle write strobe for result memory.
- `lbp_addr`, output, AW: write address.
- `lbp_data`, output, 8: LBP code.
- `finish`, output, 1: all interior pixels written; held high.

## Operation
- Reset value of every output is 0. State after reset is IDLE; row, column and step counters are cleared.
- **IDLE:** wait for `gray_ready`=1, then load row=1 and col=1, and go to READ.
- **READ** (9 cycles, step k=0..8):
  - Drive `gray_req`=1 and `gray_addr`={row-1+k/3, col-1+k%3}. The address is row·IMG_W+col, formed as a bit concatenation.
  - Each cycle, latch `gray_data` into window register g[k-1].
- **LAST** (1 cycle): `gray_req`=0; latch g[8].
- **WRITE** (1 cycle):
  - Drive `lbp_valid`=1, `lbp_addr`={row,col}, `lbp_data`=code.
  - Advance col. When col=IMG_W-2, set col=1 and increment row.
  - If the last pixel (row=col=IMG_W-2) was written, go to DONE; otherwise go to READ.
- **DONE:** `finish`=1, all strobes 0. The block stays in DONE until `rst`.
- LBP code: bit = (g[k] >= g[4]), unsigned compare. Neighbour-to-bit mapping is g0→b0, g1→b1, g2→b2, g3→b3, g5→b4, g6→b5, g7→b6, g8→b7.
- Border pixels (row or col equal to 0 or IMG_W-1) are never written.
- `lbp_addr` and `lbp_data` are registered; they hold their last values outside WRITE.
- `gray_ready` falling after the start is ignored.
- `rst` asserted mid-operation aborts immediately: all outputs go to 0, the FSM returns to IDLE, and the scan restarts from (1,1) on the next `gray_ready`.

## Timing
- Cycle 0 is the IDLE cycle that samples `gray_ready`=1. The first `gray_req` occurs in cycle 1.
- Each pixel takes 11 cycles: 9 READ, 1 LAST, 1 WRITE. `lbp_valid` for pixel n is in cycle 11n+11.
- `lbp_valid` follows the pixel's last `gray_req` cycle by 2 cycles.
- With N=(IMG_W-2)², `finish` rises in cycle 11N+1. For the defaults, N=15876 and `finish` rises in cycle 174637.
- `gray_req` and `lbp_valid` are never high in the same cycle.

## Structure
- Shared package `lbp_pkg` holds:
  - the state enum (IDLE, READ, LAST, WRITE, DONE);
  - the window size constant 9 and centre index 4;
  - the neighbour-to-bit index map.
- Sub-module `step_counter`: parameterised up-counter with `en`, synchronous `clr`, and a parameterised clear value. It is instantiated three times: col (clear value 1), row (clear value 1), and step k (clear value 0).
- The FSM, window registers and code compare live in `lbp_ctrl`.

## Test plan
1. **No start:** reset, then hold `gray_ready`=0 for 50 cycles → `gray_req`, `lbp_valid` and `finish` all stay 0.
2. **First window:** start → `gray_addr` sequence 0,1,2,128,129,130,256,257,258 in cycles 1–9. `lbp_valid` in cycle 11 with `lbp_addr`=129.
3. **Code check:** centre=100; g0..g8 = 101, 99, 100, 0, 100, 200, 100, 50, 255 → `lbp_data`=0xB5.
4. **Uniform image:** all pixels 0x55 → 15876 writes, all with `lbp_data`=0xFF. Last `lbp_addr`=16254. `finish` rises in cycle 174637 and stays high.
5. **Reset mid-run:** assert `rst` during pixel 100 → outputs are 0 immediately. After `gray_ready`, the scan restarts at `gray_addr`=0 and the first `lbp_addr`=129.
6. **Small image:** IMG_W=8, AW=6, random image → 36 writes matching a reference model, with addresses 9..54 skipping border pixels. `finish` rises in cycle 397.
